// File: rtl/alu_seq_muldiv_pkg.sv
// Shared definitions for the sequential ALU: opcode encoding (including the
// iterative MULT/MULTU/DIV/DIVU ops), FSM state encoding and the default
// datapath width.
package alu_seq_muldiv_pkg;

  localparam int unsigned W_CPU    = 32;
  localparam int unsigned W_OPCODE = 5;

  localparam logic [W_OPCODE-1:0] OpAdd   = 5'd0;
  localparam logic [W_OPCODE-1:0] OpAddu  = 5'd1;
  localparam logic [W_OPCODE-1:0] OpSub   = 5'd2;
  localparam logic [W_OPCODE-1:0] OpSubu  = 5'd3;
  localparam logic [W_OPCODE-1:0] OpAnd   = 5'd4;
  localparam logic [W_OPCODE-1:0] OpOr    = 5'd5;
  localparam logic [W_OPCODE-1:0] OpXor   = 5'd6;
  localparam logic [W_OPCODE-1:0] OpNor   = 5'd7;
  localparam logic [W_OPCODE-1:0] OpNand  = 5'd8;
  localparam logic [W_OPCODE-1:0] OpSlt   = 5'd9;
  localparam logic [W_OPCODE-1:0] OpSltu  = 5'd10;
  localparam logic [W_OPCODE-1:0] OpSll   = 5'd11;
  localparam logic [W_OPCODE-1:0] OpSrl   = 5'd12;
  localparam logic [W_OPCODE-1:0] OpSra   = 5'd13;
  localparam logic [W_OPCODE-1:0] OpMult  = 5'd14;
  localparam logic [W_OPCODE-1:0] OpMultu = 5'd15;
  localparam logic [W_OPCODE-1:0] OpDiv   = 5'd16;
  localparam logic [W_OPCODE-1:0] OpDivu  = 5'd17;

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StOut} state_e;

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative multiply/divide datapath.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   start_i             latch operands and begin W iterations
//   is_div_i            1: restoring divide, 0: shift-add multiply
//   is_signed_i         operands are two's complement
//   a_i, b_i            operands (multiplicand/dividend, multiplier/divisor)
//   done_o              high during the last iteration; results valid next cycle
//   hi_o, lo_o          sign-corrected product high/low or remainder/quotient
//   ovf_o               signed INT_MIN / -1
module alu_muldiv_core #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         is_div_i,
  input  logic         is_signed_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         done_o,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o,
  output logic         ovf_o
);

  localparam int unsigned CntW = $clog2(W);

  logic            run_q, run_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            div_q, div_d;
  logic            neg_q, neg_d;       // negate product / quotient
  logic            neg_rem_q, neg_rem_d;
  logic            ovf_q, ovf_d;
  logic [W-1:0]    mag_q, mag_d;       // |multiplicand| or |divisor|
  logic [W-1:0]    hi_q, hi_d;         // product high / partial remainder
  logic [W-1:0]    lo_q, lo_d;         // multiplier / dividend -> quotient

  logic            sa, sb;
  logic [W-1:0]    abs_a, abs_b;
  logic [W:0]      sum, trial;
  logic [2*W-1:0]  prod;

  assign done_o = run_q && (cnt_q == CntW'(W - 1));

  always_comb begin
    sa    = is_signed_i & a_i[W-1];
    sb    = is_signed_i & b_i[W-1];
    abs_a = sa ? -a_i : a_i;
    abs_b = sb ? -b_i : b_i;
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
    // Negative trial (top bit set) means the divisor does not fit: restore.
    trial = {hi_q, lo_q[W-1]} - {1'b0, mag_q};

    run_d     = run_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    ovf_d     = ovf_q;
    mag_d     = mag_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (start_i) begin
      run_d     = 1'b1;
      cnt_d     = '0;
      div_d     = is_div_i;
      neg_d     = sa ^ sb;
      neg_rem_d = sa;
      ovf_d     = is_div_i && is_signed_i && (a_i == {1'b1, {(W-1){1'b0}}}) && (b_i == '1);
      mag_d     = is_div_i ? abs_b : abs_a;
      hi_d      = '0;
      lo_d      = is_div_i ? abs_a : abs_b;
    end else if (run_q) begin
      cnt_d = cnt_q + CntW'(1);
      if (done_o) run_d = 1'b0;
      if (div_q) begin
        if (!trial[W]) begin
          hi_d = trial[W-1:0];
          lo_d = {lo_q[W-2:0], 1'b1};
        end else begin
          hi_d = {hi_q[W-2:0], lo_q[W-1]};
          lo_d = {lo_q[W-2:0], 1'b0};
        end
      end else begin
        hi_d = sum[W:1];
        lo_d = {sum[0], lo_q[W-1:1]};
      end
    end
  end

  always_comb begin
    prod = {hi_q, lo_q};
    if (div_q) begin
      lo_o = neg_q ? -lo_q : lo_q;
      hi_o = neg_rem_q ? -hi_q : hi_q;
    end else begin
      {hi_o, lo_o} = neg_q ? -prod : prod;
    end
    ovf_o = ovf_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q     <= 1'b0;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      ovf_q     <= 1'b0;
      mag_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      run_q     <= run_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      ovf_q     <= ovf_d;
      mag_q     <= mag_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: rtl/alu_seq_muldiv.sv
// Registered ALU with iterative multiply/divide behind valid/ready handshakes.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     operation handshake (ready only when idle)
//   alu_op, A, B            opcode and operands, latched at accept
//   out_valid / out_ready   result handshake; outputs held until consumed
//   R, R_hi                 result (LO / quotient), HI / remainder
//   overflow, isZero        signed overflow, R == 0
//   div_zero, busy          divide by zero, FSM not idle
module alu_seq_muldiv
  import alu_seq_muldiv_pkg::*;
#(
  parameter int unsigned W    = W_CPU,
  parameter int unsigned W_OP = W_OPCODE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W_OP-1:0] alu_op,
  input  logic [W-1:0]    A,
  input  logic [W-1:0]    B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    R,
  output logic [W-1:0]    R_hi,
  output logic            overflow,
  output logic            isZero,
  output logic            div_zero,
  output logic            busy
);

  localparam int unsigned W_SH = $clog2(W);

  state_e        state_q, state_d;
  logic [W-1:0]  r_q, r_d, r_hi_q, r_hi_d;
  logic          ovf_q, ovf_d, dz_q, dz_d;

  logic [W_OPCODE-1:0] op;
  logic                op_in_range, is_mul, is_div, is_signed;
  logic [W-1:0]        sum, diff, alu_r;
  logic [W_SH-1:0]     shamt;
  logic                alu_ovf;
  logic                core_start, core_done, core_ovf;
  logic [W-1:0]        core_hi, core_lo;

  assign op          = alu_op[W_OPCODE-1:0];
  assign op_in_range = (alu_op >> W_OPCODE) == '0;
  assign is_mul      = op_in_range && (op == OpMult || op == OpMultu);
  assign is_div      = op_in_range && (op == OpDiv || op == OpDivu);
  assign is_signed   = (op == OpMult) || (op == OpDiv);
  assign sum         = A + B;
  assign diff        = A - B;
  assign shamt       = B[W_SH-1:0];

  always_comb begin
    alu_r   = '0;
    alu_ovf = 1'b0;
    if (op_in_range) begin
      case (op)
        OpAdd: begin
          alu_r   = sum;
          alu_ovf = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
        end
        OpSub: begin
          alu_r   = diff;
          alu_ovf = (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1]);
        end
        OpAddu:  alu_r = sum;
        OpSubu:  alu_r = diff;
        OpAnd:   alu_r = A & B;
        OpOr:    alu_r = A | B;
        OpXor:   alu_r = A ^ B;
        OpNor:   alu_r = ~(A | B);
        OpNand:  alu_r = ~(A & B);
        OpSlt:   alu_r = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
        OpSltu:  alu_r = {{(W-1){1'b0}}, (A < B)};
        OpSll:   alu_r = A << shamt;
        OpSrl:   alu_r = A >> shamt;
        OpSra:   alu_r = $signed(A) >>> shamt;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    r_hi_d     = r_hi_q;
    ovf_d      = ovf_q;
    dz_d       = dz_q;
    core_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (is_mul) begin
            core_start = 1'b1;
            state_d    = StMul;
          end else if (is_div && B != '0) begin
            core_start = 1'b1;
            state_d    = StDiv;
          end else if (is_div) begin
            r_d     = '1;
            r_hi_d  = A;
            ovf_d   = 1'b0;
            dz_d    = 1'b1;
            state_d = StOut;
          end else begin
            r_d     = alu_r;
            r_hi_d  = '0;
            ovf_d   = alu_ovf;
            dz_d    = 1'b0;
            state_d = StOut;
          end
        end
      end
      StMul, StDiv: if (core_done) state_d = StFix;
      StFix: begin
        r_d     = core_lo;
        r_hi_d  = core_hi;
        ovf_d   = core_ovf;
        dz_d    = 1'b0;
        state_d = StOut;
      end
      StOut:   if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      r_q     <= '0;
      r_hi_q  <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      r_hi_q  <= r_hi_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  alu_muldiv_core #(
    .W(W)
  ) u_core (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (core_start),
    .is_div_i   (is_div),
    .is_signed_i(is_signed),
    .a_i        (A),
    .b_i        (B),
    .done_o     (core_done),
    .hi_o       (core_hi),
    .lo_o       (core_lo),
    .ovf_o      (core_ovf)
  );

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign R         = r_q;
  assign R_hi      = r_hi_q;
  assign overflow  = ovf_q;
  assign div_zero  = dz_q;
  assign isZero    = (r_q == '0);

endmodule
